// File: rtl/lifo_stack_if.sv
// lifo_stack_if: push/pop/status bundle for lifo_stack.
//   master : producer/consumer side (drives push, wr_data, pop)
//   slave  : stack side (drives rd_data, rd_valid, full, empty, count)
// Optional macro LIFO_ERR_FLAGS_EN adds err_clr (master->slave) and the
// sticky overflow/underflow flags (slave->master).
interface lifo_stack_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
);
    logic                         push;
    logic [DATA_WIDTH-1:0]        wr_data;
    logic                         pop;
    logic [DATA_WIDTH-1:0]        rd_data;
    logic                         rd_valid;
    logic                         full;
    logic                         empty;
    logic [$clog2(DEPTH+1)-1:0]   count;
`ifdef LIFO_ERR_FLAGS_EN
    logic                         err_clr;
    logic                         overflow;
    logic                         underflow;

    modport master (output push, wr_data, pop, err_clr,
                    input  rd_data, rd_valid, full, empty, count, overflow, underflow);
    modport slave  (input  push, wr_data, pop, err_clr,
                    output rd_data, rd_valid, full, empty, count, overflow, underflow);
`else
    modport master (output push, wr_data, pop,
                    input  rd_data, rd_valid, full, empty, count);
    modport slave  (input  push, wr_data, pop,
                    output rd_data, rd_valid, full, empty, count);
`endif
endinterface

// File: rtl/lifo_stack.sv
// lifo_stack: synchronous LIFO of DATA_WIDTH-bit words, DEPTH entries deep.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - lifo_stack_if.slave: push/wr_data/pop in; rd_data/rd_valid
//           (registered pop data + one-cycle strobe), full/empty/count out
// Optional macro LIFO_ERR_FLAGS_EN: sticky overflow/underflow flags cleared
// by err_clr. Without it, illegal operations are silently ignored.
module lifo_stack #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    lifo_stack_if.slave   bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  full_w, empty_w;
    logic                  do_push, do_pop;
    logic [AW-1:0]         top_idx, wr_idx;

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    always_comb begin
        do_pop  = bus.pop && !empty_w;
        // A push into a full stack is legal only when a pop frees the top slot.
        do_push = bus.push && (!full_w || do_pop);
        top_idx = AW'(count_q - CW'(1));
        // Push+pop replaces the current top; a lone push goes above it.
        wr_idx  = do_pop ? top_idx : AW'(count_q);

        count_d = count_q;
        if (do_push && !do_pop)
            count_d = count_q + CW'(1);
        else if (do_pop && !do_push)
            count_d = count_q - CW'(1);

        rd_data_d  = do_pop ? mem_q[top_idx] : rd_data_q;
        rd_valid_d = do_pop;
    end

    // Storage has no reset; contents are discarded logically via count.
    always_ff @(posedge clk) begin
        if (do_push)
            mem_q[wr_idx] <= bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.full     = full_w;
    assign bus.empty    = empty_w;
    assign bus.count    = count_q;

`ifdef LIFO_ERR_FLAGS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Set has priority over clear when both happen on the same edge.
    always_comb begin
        overflow_d  = bus.err_clr ? 1'b0 : overflow_q;
        underflow_d = bus.err_clr ? 1'b0 : underflow_q;
        if (bus.push && !bus.pop && full_w)
            overflow_d = 1'b1;
        if (bus.pop && !bus.push && empty_w)
            underflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_lifo_stack.sv
// tb_lifo_stack: directed bench for lifo_stack (DEPTH=4, DATA_WIDTH=32).
// Stimulus queues the hand-computed data each accepted pop must return; a
// separate monitor pops that queue whenever rd_valid is seen.
module tb_lifo_stack;
    localparam int DW = 32;
    localparam int DP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lifo_stack_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();
    lifo_stack #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0;
    int checks = 0;
    logic [DW-1:0] exp_q [$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rd_valid strobe must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n && bus.rd_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_rd_valid: got rd_data %0h expected no strobe", bus.rd_data);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (bus.rd_data !== e) begin
                    errors++;
                    $display("FAIL pop_data: got %0h expected %0h", bus.rd_data, e);
                end
            end
        end
    end

    // One clock of stimulus; exp_valid means this pop should be accepted.
    task automatic op(input logic p, input logic [DW-1:0] d, input logic q,
                      input logic exp_valid, input logic [DW-1:0] exp_data);
        @(negedge clk);
        bus.push = p;
        bus.wr_data = d;
        bus.pop = q;
        if (exp_valid) exp_q.push_back(exp_data);
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop = 1'b0;
    endtask

    task automatic do_push(input logic [DW-1:0] d);
        op(1'b1, d, 1'b0, 1'b0, '0);
    endtask

    task automatic do_pop(input logic [DW-1:0] e);
        op(1'b0, '0, 1'b1, 1'b1, e);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.push = 1'b0;
        bus.pop = 1'b0;
        bus.wr_data = '0;
`ifdef LIFO_ERR_FLAGS_EN
        bus.err_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_empty", bus.empty, 1);
        chk("reset_full", bus.full, 0);
        chk("reset_count", bus.count, 0);
        chk("reset_rd_data", bus.rd_data, 0);
        chk("reset_rd_valid", bus.rd_valid, 0);

        do_push(32'h11); do_push(32'h22); do_push(32'h33); do_push(32'h44);
        chk("fill_count", bus.count, 4);
        chk("fill_full", bus.full, 1);
        chk("fill_empty", bus.empty, 0);

        do_push(32'h55);
        chk("ovf_count", bus.count, 4);
`ifdef LIFO_ERR_FLAGS_EN
        chk("overflow_set", bus.overflow, 1);
`endif

        do_pop(32'h44); do_pop(32'h33); do_pop(32'h22); do_pop(32'h11);
        chk("drain_empty", bus.empty, 1);
        chk("drain_count", bus.count, 0);

        op(1'b0, '0, 1'b1, 1'b0, '0);
        chk("udf_rd_valid", bus.rd_valid, 0);
        chk("udf_rd_data_hold", bus.rd_data, 32'h11);
        chk("udf_count", bus.count, 0);
`ifdef LIFO_ERR_FLAGS_EN
        chk("underflow_set", bus.underflow, 1);
        chk("overflow_sticky", bus.overflow, 1);
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(posedge clk);
        #1;
        bus.err_clr = 1'b0;
        chk("overflow_clr", bus.overflow, 0);
        chk("underflow_clr", bus.underflow, 0);
`endif

        do_push(32'hA1); do_push(32'hB2);
        op(1'b1, 32'hC3, 1'b1, 1'b1, 32'hB2);
        chk("pushpop_rd_valid", bus.rd_valid, 1);
        chk("pushpop_count", bus.count, 2);
        do_pop(32'hC3); do_pop(32'hA1);
        chk("pushpop_empty", bus.empty, 1);

        op(1'b1, 32'h77, 1'b1, 1'b0, '0);
        chk("empty_pushpop_count", bus.count, 1);
        chk("empty_pushpop_rd_valid", bus.rd_valid, 0);
        do_pop(32'h77);

        do_push(32'h1); do_push(32'h2); do_push(32'h3); do_push(32'h4);
        op(1'b1, 32'h5, 1'b1, 1'b1, 32'h4);
        chk("full_pushpop_count", bus.count, 4);
        chk("full_pushpop_full", bus.full, 1);
        do_pop(32'h5); do_pop(32'h3); do_pop(32'h2); do_pop(32'h1);
        chk("full_pushpop_empty", bus.empty, 1);

        do_push(32'hD1); do_push(32'hD2); do_push(32'hD3);
        chk("pre_reset_count", bus.count, 3);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_count", bus.count, 0);
        chk("async_reset_empty", bus.empty, 1);
        @(negedge clk);
        rst_n = 1'b1;
        op(1'b0, '0, 1'b1, 1'b0, '0);
        chk("post_reset_pop_valid", bus.rd_valid, 0);
        chk("post_reset_rd_data", bus.rd_data, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lifo_stack.md
Name: lifo_stack

Overview:
- Synchronous last-in-first-out buffer (stack) of DATA_WIDTH-bit words, DEPTH entries deep.
- Used as a generic buffering utility, e.g. for return-address or undo stacks, between a producer and consumer sharing one clock.
- Provides full/empty/occupancy status and registered pop data with a valid strobe.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- DEPTH, 16, number of entries; any integer >= 2, not required to be a power of two.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push  input  1  write wr_data onto top of stack this cycle.
- wr_data  input  DATA_WIDTH  data to push.
- pop  input  1  remove top entry this cycle.
- rd_data  output  DATA_WIDTH  registered popped word.
- rd_valid  output  1  one-cycle strobe: rd_data updated by an accepted pop.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  $clog2(DEPTH+1)  current number of stored entries.

Behaviour:
- Reset (rst_n low, asynchronous assert; synchronous release on next clk edge): count=0, empty=1, full=0, rd_data=0, rd_valid=0; storage array is not reset.
- Stack pointer sp = count; top entry lives at index count-1.
- Accepted push (push=1, pop=0, !full): mem[count] <= wr_data; count+1 at next edge.
- Accepted pop (pop=1, push=0, !empty): rd_data <= mem[count-1]; rd_valid=1 the following cycle; count-1.
- Push while full (pop=0): ignored, no state change, stored data untouched.
- Pop while empty (push=0): ignored, rd_valid stays 0, rd_data holds its previous value.
- Simultaneous push and pop, !empty (including full): rd_data <= old top, rd_valid=1, mem[count-1] <= wr_data, count unchanged.
- Simultaneous push and pop while empty: pop ignored, push accepted, count becomes 1, rd_valid=0.
- rd_valid is high for exactly one cycle per accepted pop; back-to-back pops give back-to-back strobes.
- full, empty and count are registered/derived from count only; they reflect the state after the last edge, with no combinational path from push/pop.
- Latency: pushed data is poppable the cycle after push; popped data appears on rd_data one cycle after the pop edge.
- Reset mid-operation: all contents are logically discarded (count=0) immediately on rst_n falling.

Optional Feature:
- Macro LIFO_ERR_FLAGS_EN.
- Defined: adds two outputs, overflow (1 bit) and underflow (1 bit), plus an input err_clr (1 bit).
  - overflow is set on push while full without simultaneous pop.
  - underflow is set on pop while empty without simultaneous push.
  - Both flags are sticky until err_clr=1 at a clock edge or reset.
  - If a set condition and err_clr occur together, set wins.
  - Reset value of both flags is 0.
- Not defined: these ports and their logic do not exist; illegal operations are silently ignored as above.

Test Plan:
- Reset then idle 3 cycles -> empty=1, full=0, count=0, rd_data=0, rd_valid=0.
- DEPTH=4: push 0x11,0x22,0x33,0x44 on consecutive cycles -> count=4, full=1. Then 4 pops -> rd_data 0x44,0x33,0x22,0x11 with rd_valid each cycle; finally empty=1.
- Full stack (DEPTH=4), push 0x55 -> count stays 4; subsequent pops still return 0x44 first. Pop on empty -> rd_valid=0, rd_data unchanged, count=0; with LIFO_ERR_FLAGS_EN, overflow=1 then underflow=1 until err_clr.
- Stack holding 0xA1,0xB2: push 0xC3 with pop same cycle -> rd_data=0xB2, rd_valid=1, count=2; next pop returns 0xC3, then 0xA1.
- Push 0x77 and pop together while empty -> count=1, rd_valid=0; next pop returns 0x77.
- Push 3 words, assert rst_n low mid-cycle -> count=0, empty=1 immediately; after release, pop -> rd_valid=0.
